umidev_arbiter: RTL and testbench
=================================

# umidev_arbiter

Shares one UMI register-target device (a `umidev` instance) among N UMI requesters. Arbitration is round-robin. The block allows exactly one transaction in flight at a time. It registers the granted request toward the device and routes the device's response back to the requester that issued it. It sits between the host-side UMI fabric ports and the `udev_*` port of the register target.

## Interface
- N, 4: number of requester ports (2..8)
- CW, 32: command width
- AW, 64: address width
- DW, 64: data width
- clk  input  1  clock
- nreset  input  1  reset, asynchronous, active-low
- host_req_valid  input  N  per-port request valid
- host_req_cmd  input  N*CW  per-port command, port i at [i*CW+:CW]
- host_req_dstaddr  input  N*AW  per-port destination address
- host_req_srcaddr  input  N*AW  per-port source address
- host_req_data  input  N*DW  per-port write data
- host_req_ready  output  N  per-port request ready, at most one bit set
- host_resp_valid  output  N  per-port response valid, at most one bit set
- host_resp_cmd  output  CW  response command, shared by all ports
- host_resp_dstaddr  output  AW  response destination address, shared
- host_resp_srcaddr  output  AW  response source address, shared
- host_resp_data  output  DW  response data, shared
- host_resp_ready  input  N  per-port response ready
- dev_req_valid / dev_req_cmd / dev_req_dstaddr / dev_req_srcaddr / dev_req_data  output  1/CW/AW/AW/DW  request to device
- dev_req_ready  input  1  device request ready
- dev_resp_valid / dev_resp_cmd / dev_resp_dstaddr / dev_resp_srcaddr / dev_resp_data  input  1/CW/AW/AW/DW  response from device
- dev_resp_ready  output  1  device response ready

## Operation
- State machine with four states.
  - IDLE
    - Round-robin pick among asserted host_req_valid, starting at priority pointer `ptr`.
    - Combinationally assert host_req_ready[winner] (only in IDLE; ready may depend on valid).
    - On beat: capture cmd, dstaddr, srcaddr and data into the request register, record owner = winner, set ptr = (winner+1) mod N, go to ISSUE.
  - ISSUE
    - dev_req_valid=1, driven from the request register.
    - On dev_req_ready: if the expects-response flag (`rsp`) is set, go to WAIT; otherwise go to IDLE.
  - WAIT
    - dev_resp_ready=1.
    - On dev_resp_valid: capture all response fields into the response register, go to RESP.
  - RESP
    - host_resp_valid[owner]=1, driven from the response register.
    - On host_resp_ready[owner]: go to IDLE.
- rsp=1 iff cmd[4:0] is UMI_REQ_READ or UMI_REQ_WRITE. Posted, atomic and all other opcodes get no response.
- dev_resp_ready=0 outside WAIT. A device response in any other state is held off and not lost.
- host_resp_ready of non-owner ports is ignored.
- ptr advances only on a grant. An idle requester is skipped with no extra cycle.
- The block does not modify any payload field.

## Timing
- Reset values:
  - state=IDLE, ptr=0 (port 0 highest priority)
  - all valid and ready outputs 0, except host_req_ready, which is combinational and follows the IDLE arbitration as soon as reset releases
  - request, response and owner registers 0
- Request latency: host beat at cycle T gives dev_req_valid high at T+1.
- Response latency: dev_resp beat at cycle R gives host_resp_valid high at R+1.
- Back-to-back: a response beat at cycle R returns to IDLE at R+1, so the next grant is possible in cycle R+1.
- Minimum posted rate: one transaction per 2 cycles when the device is always ready. The beat in IDLE moves to ISSUE; the device beat in ISSUE moves back to IDLE.
- Simultaneous valids: exactly one grant per IDLE cycle. Losers keep valid asserted and are served in rotation.
- No combinational path from any dev_* input to any host_* output, or the reverse.
- Reset mid-operation: any in-flight transaction is dropped, no response is issued, and the block returns to its reset state immediately.

## Structure
- State encoding (IDLE, ISSUE, WAIT, RESP) as localparams in the shared `umi_messages.vh`-style header, alongside the UMI opcode constants already used there.
- One sub-module, `umidev_rrarb`:
  - Parameter N.
  - Inputs: request vector, ptr.
  - Output: one-hot grant vector plus binary index.
  - Purely combinational.
- Top level holds the FSM, ptr, owner, request register and response register.

## Test plan
- Single write: port 2 sends a UMI_REQ_WRITE to addr 0x4 with data 0xDEADBEEF; the device returns UMI_RESP_WRITE.
  - host_resp_valid = 4'b0100.
  - host_resp_dstaddr equals the original srcaddr.
  - No other port sees valid.
- Read after write: port 0 writes 0x1234 to addr 0x8, then reads addr 0x8 -> host_resp_data = 0x1234 and host_resp_cmd[4:0] = UMI_RESP_READ.
- Fairness: all 4 ports hold valid continuously with posted writes -> grants go 0,1,2,3,0,… with no port granted twice in any window of 4 grants.
- Posted write: after the dev beat the FSM returns to IDLE, and no host_resp_valid is ever asserted.
- Backpressure: the owner holds host_resp_ready=0 for 10 cycles while other ports are valid.
  - host_resp_valid and the response payload stay stable.
  - No host_req_ready is asserted until the response beat.
- Reset mid-transaction: assert nreset low during WAIT -> all outputs go to reset values within the same cycle; after release, a fresh request from port 0 completes normally.

Source files
------------

// File: rtl/umidev_arbiter_pkg.sv
// Shared definitions for the umidev arbiter: UMI opcodes and FSM state encoding.
package umidev_arbiter_pkg;

    // UMI request opcodes (cmd[4:0])
    localparam logic [4:0] UMI_REQ_READ    = 5'h01;
    localparam logic [4:0] UMI_REQ_WRITE   = 5'h03;
    localparam logic [4:0] UMI_REQ_POSTED  = 5'h05;
    localparam logic [4:0] UMI_REQ_RDMA    = 5'h07;
    localparam logic [4:0] UMI_REQ_ATOMIC  = 5'h09;

    // UMI response opcodes (cmd[4:0])
    localparam logic [4:0] UMI_RESP_READ   = 5'h02;
    localparam logic [4:0] UMI_RESP_WRITE  = 5'h04;

    // Arbiter FSM encoding
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StResp  = 2'd3
    } arb_state_e;

    // Only reads and acknowledged writes produce a device response.
    function automatic logic umi_expects_resp(input logic [4:0] opcode);
        return (opcode == UMI_REQ_READ) || (opcode == UMI_REQ_WRITE);
    endfunction

endpackage

// File: rtl/umidev_rrarb.sv
// Combinational round-robin picker: first asserted request at or after ptr wins.
module umidev_rrarb #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx
);

    logic          found;
    logic [PW-1:0] idx;

    // Scan from ptr upward with wraparound; the first hit is the winner.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = PW'((32'(ptr) + i) % N);
            if (!found && req[idx]) begin
                found          = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = idx;
            end
        end
    end

endmodule

// File: rtl/umidev_arbiter.sv
// Shares one UMI register target among N requesters, one transaction in flight.
module umidev_arbiter
    import umidev_arbiter_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned CW = 32,
    parameter int unsigned AW = 64,
    parameter int unsigned DW = 64
) (
    input  logic            clk,
    input  logic            nreset,
    // host side requests
    input  logic [N-1:0]    host_req_valid,
    input  logic [N*CW-1:0] host_req_cmd,
    input  logic [N*AW-1:0] host_req_dstaddr,
    input  logic [N*AW-1:0] host_req_srcaddr,
    input  logic [N*DW-1:0] host_req_data,
    output logic [N-1:0]    host_req_ready,
    // host side responses
    output logic [N-1:0]    host_resp_valid,
    output logic [CW-1:0]   host_resp_cmd,
    output logic [AW-1:0]   host_resp_dstaddr,
    output logic [AW-1:0]   host_resp_srcaddr,
    output logic [DW-1:0]   host_resp_data,
    input  logic [N-1:0]    host_resp_ready,
    // device side requests
    output logic            dev_req_valid,
    output logic [CW-1:0]   dev_req_cmd,
    output logic [AW-1:0]   dev_req_dstaddr,
    output logic [AW-1:0]   dev_req_srcaddr,
    output logic [DW-1:0]   dev_req_data,
    input  logic            dev_req_ready,
    // device side responses
    input  logic            dev_resp_valid,
    input  logic [CW-1:0]   dev_resp_cmd,
    input  logic [AW-1:0]   dev_resp_dstaddr,
    input  logic [AW-1:0]   dev_resp_srcaddr,
    input  logic [DW-1:0]   dev_resp_data,
    output logic            dev_resp_ready
);

    localparam int unsigned PW = $clog2(N);

    arb_state_e    state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] owner_q, owner_d;

    logic [CW-1:0] req_cmd_q;
    logic [AW-1:0] req_dstaddr_q;
    logic [AW-1:0] req_srcaddr_q;
    logic [DW-1:0] req_data_q;

    logic [CW-1:0] resp_cmd_q;
    logic [AW-1:0] resp_dstaddr_q;
    logic [AW-1:0] resp_srcaddr_q;
    logic [DW-1:0] resp_data_q;

    logic [N-1:0]  grant;
    logic [PW-1:0] grant_idx;
    logic          req_load;
    logic          resp_load;

    umidev_rrarb #(
        .N  (N),
        .PW (PW)
    ) u_rrarb (
        .req       (host_req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Next-state, grant and handshake decode.
    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        owner_d         = owner_q;
        req_load        = 1'b0;
        resp_load       = 1'b0;
        host_req_ready  = '0;
        host_resp_valid = '0;
        dev_req_valid   = 1'b0;
        dev_resp_ready  = 1'b0;
        case (state_q)
            StIdle: begin
                // Ready equals grant, so any asserted valid is a beat.
                host_req_ready = grant;
                if (|host_req_valid) begin
                    req_load = 1'b1;
                    owner_d  = grant_idx;
                    ptr_d    = (grant_idx == PW'(N - 1)) ? '0 : grant_idx + 1'b1;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                dev_req_valid = 1'b1;
                if (dev_req_ready) begin
                    state_d = umi_expects_resp(req_cmd_q[4:0]) ? StWait : StIdle;
                end
            end
            StWait: begin
                dev_resp_ready = 1'b1;
                if (dev_resp_valid) begin
                    resp_load = 1'b1;
                    state_d   = StResp;
                end
            end
            StResp: begin
                host_resp_valid[owner_q] = 1'b1;
                if (host_resp_ready[owner_q]) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM, priority pointer and owner.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    // Request register, loaded from the winning port on the host beat.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            req_cmd_q     <= '0;
            req_dstaddr_q <= '0;
            req_srcaddr_q <= '0;
            req_data_q    <= '0;
        end else if (req_load) begin
            req_cmd_q     <= host_req_cmd[32'(grant_idx) * CW +: CW];
            req_dstaddr_q <= host_req_dstaddr[32'(grant_idx) * AW +: AW];
            req_srcaddr_q <= host_req_srcaddr[32'(grant_idx) * AW +: AW];
            req_data_q    <= host_req_data[32'(grant_idx) * DW +: DW];
        end
    end

    // Response register, loaded on the device response beat.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            resp_cmd_q     <= '0;
            resp_dstaddr_q <= '0;
            resp_srcaddr_q <= '0;
            resp_data_q    <= '0;
        end else if (resp_load) begin
            resp_cmd_q     <= dev_resp_cmd;
            resp_dstaddr_q <= dev_resp_dstaddr;
            resp_srcaddr_q <= dev_resp_srcaddr;
            resp_data_q    <= dev_resp_data;
        end
    end

    assign dev_req_cmd       = req_cmd_q;
    assign dev_req_dstaddr   = req_dstaddr_q;
    assign dev_req_srcaddr   = req_srcaddr_q;
    assign dev_req_data      = req_data_q;

    assign host_resp_cmd     = resp_cmd_q;
    assign host_resp_dstaddr = resp_dstaddr_q;
    assign host_resp_srcaddr = resp_srcaddr_q;
    assign host_resp_data    = resp_data_q;

endmodule

// File: tb/tb_umidev_arbiter.sv
// Directed bench for umidev_arbiter; the bench plays both the requesters and the device.
module tb_umidev_arbiter;

    localparam int N  = 4;
    localparam int CW = 32;
    localparam int AW = 64;
    localparam int DW = 64;

    logic            clk;
    logic            nreset;
    logic [N-1:0]    host_req_valid;
    logic [N*CW-1:0] host_req_cmd;
    logic [N*AW-1:0] host_req_dstaddr;
    logic [N*AW-1:0] host_req_srcaddr;
    logic [N*DW-1:0] host_req_data;
    logic [N-1:0]    host_req_ready;
    logic [N-1:0]    host_resp_valid;
    logic [CW-1:0]   host_resp_cmd;
    logic [AW-1:0]   host_resp_dstaddr;
    logic [AW-1:0]   host_resp_srcaddr;
    logic [DW-1:0]   host_resp_data;
    logic [N-1:0]    host_resp_ready;
    logic            dev_req_valid;
    logic [CW-1:0]   dev_req_cmd;
    logic [AW-1:0]   dev_req_dstaddr;
    logic [AW-1:0]   dev_req_srcaddr;
    logic [DW-1:0]   dev_req_data;
    logic            dev_req_ready;
    logic            dev_resp_valid;
    logic [CW-1:0]   dev_resp_cmd;
    logic [AW-1:0]   dev_resp_dstaddr;
    logic [AW-1:0]   dev_resp_srcaddr;
    logic [DW-1:0]   dev_resp_data;
    logic            dev_resp_ready;

    int n_pass;
    int n_total;

    umidev_arbiter #(
        .N  (N),
        .CW (CW),
        .AW (AW),
        .DW (DW)
    ) dut (
        .clk               (clk),
        .nreset            (nreset),
        .host_req_valid    (host_req_valid),
        .host_req_cmd      (host_req_cmd),
        .host_req_dstaddr  (host_req_dstaddr),
        .host_req_srcaddr  (host_req_srcaddr),
        .host_req_data     (host_req_data),
        .host_req_ready    (host_req_ready),
        .host_resp_valid   (host_resp_valid),
        .host_resp_cmd     (host_resp_cmd),
        .host_resp_dstaddr (host_resp_dstaddr),
        .host_resp_srcaddr (host_resp_srcaddr),
        .host_resp_data    (host_resp_data),
        .host_resp_ready   (host_resp_ready),
        .dev_req_valid     (dev_req_valid),
        .dev_req_cmd       (dev_req_cmd),
        .dev_req_dstaddr   (dev_req_dstaddr),
        .dev_req_srcaddr   (dev_req_srcaddr),
        .dev_req_data      (dev_req_data),
        .dev_req_ready     (dev_req_ready),
        .dev_resp_valid    (dev_resp_valid),
        .dev_resp_cmd      (dev_resp_cmd),
        .dev_resp_dstaddr  (dev_resp_dstaddr),
        .dev_resp_srcaddr  (dev_resp_srcaddr),
        .dev_resp_data     (dev_resp_data),
        .dev_resp_ready    (dev_resp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request on port p and hold it until granted; returns aligned after the beat.
    task automatic host_issue(input int p, input logic [CW-1:0] cmd, input logic [AW-1:0] dst,
                              input logic [AW-1:0] src, input logic [DW-1:0] data,
                              output bit ok);
        host_req_cmd[p*CW +: CW]     = cmd;
        host_req_dstaddr[p*AW +: AW] = dst;
        host_req_srcaddr[p*AW +: AW] = src;
        host_req_data[p*DW +: DW]    = data;
        host_req_valid[p]            = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (host_req_ready[p]) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) tick();
        host_req_valid[p] = 1'b0;
    endtask

    // Device accepts the pending request.
    task automatic dev_accept(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (dev_req_valid) begin
                dev_req_ready = 1'b1;
                tick();
                dev_req_ready = 1'b0;
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Device presents a response until it is taken.
    task automatic dev_respond(input logic [CW-1:0] cmd, input logic [AW-1:0] dst,
                               input logic [AW-1:0] src, input logic [DW-1:0] data,
                               output bit ok);
        dev_resp_cmd     = cmd;
        dev_resp_dstaddr = dst;
        dev_resp_srcaddr = src;
        dev_resp_data    = data;
        dev_resp_valid   = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (dev_resp_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        dev_resp_valid = 1'b0;
    endtask

    task automatic host_take(input int p);
        host_resp_ready[p] = 1'b1;
        tick();
        host_resp_ready[p] = 1'b0;
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if ({dev_req_valid, dev_resp_ready, host_resp_valid, host_req_ready} !== 10'b0)
            $display("FAIL reset_valids: got %b want 0",
                     {dev_req_valid, dev_resp_ready, host_resp_valid, host_req_ready});
        else n_pass++;
        n_total++;
        if ({host_resp_data, dev_req_cmd, dev_req_dstaddr} !== 160'h0)
            $display("FAIL reset_regs: got %h want 0",
                     {host_resp_data, dev_req_cmd, dev_req_dstaddr});
        else n_pass++;
        nreset = 1'b1;
        tick();
        host_req_valid = 4'b0110;
        #1;
        n_total++;
        if (host_req_ready !== 4'b0010)
            $display("FAIL reset_ptr_grant: got %b want 0010", host_req_ready);
        else n_pass++;
        host_req_valid = 4'b0000;
    endtask

    task automatic test_fairness();
        logic [N-1:0]  exp_grant;
        logic [AW-1:0] exp_dst;
        tick();
        for (int p = 0; p < N; p++) begin
            host_req_cmd[p*CW +: CW]     = 32'h0000_0005;
            host_req_dstaddr[p*AW +: AW] = 64'h100 + 64'(p);
            host_req_srcaddr[p*AW +: AW] = 64'h0;
            host_req_data[p*DW +: DW]    = 64'(p);
        end
        host_req_valid = 4'b1111;
        dev_req_ready  = 1'b1;
        for (int g = 0; g < 8; g++) begin
            exp_grant = 4'b0001 << (g % 4);
            exp_dst   = 64'h100 + 64'(g % 4);
            #1;
            n_total++;
            if (host_req_ready !== exp_grant)
                $display("FAIL fair_grant%0d: got %b want %b", g, host_req_ready, exp_grant);
            else n_pass++;
            tick();
            n_total++;
            if ({dev_req_valid, dev_req_dstaddr, host_req_ready} !== {1'b1, exp_dst, 4'b0})
                $display("FAIL fair_issue%0d: got %b/%h/%b want 1/%h/0000", g, dev_req_valid,
                         dev_req_dstaddr, host_req_ready, exp_dst);
            else n_pass++;
            tick();
        end
        host_req_valid = 4'b0000;
        dev_req_ready  = 1'b0;
        n_total++;
        if ({host_resp_valid, dev_resp_ready} !== 5'b0)
            $display("FAIL fair_no_resp: got %b want 0", {host_resp_valid, dev_resp_ready});
        else n_pass++;
    endtask

    task automatic test_single_write();
        bit ok;
        host_issue(2, 32'h0001_0003, 64'h4, 64'h0000_0002_0000_0000, 64'hDEAD_BEEF, ok);
        n_total++;
        if ({ok, dev_req_valid} !== 2'b11)
            $display("FAIL sw_issue: got %b want 11", {ok, dev_req_valid});
        else n_pass++;
        n_total++;
        if ({dev_req_cmd, dev_req_dstaddr, dev_req_srcaddr, dev_req_data} !==
            {32'h0001_0003, 64'h4, 64'h0000_0002_0000_0000, 64'hDEAD_BEEF})
            $display("FAIL sw_payload: got %h %h %h %h", dev_req_cmd, dev_req_dstaddr,
                     dev_req_srcaddr, dev_req_data);
        else n_pass++;
        dev_accept(ok);
        n_total++;
        if ({ok, dev_resp_ready} !== 2'b11)
            $display("FAIL sw_wait: got %b want 11", {ok, dev_resp_ready});
        else n_pass++;
        dev_respond(32'h0001_0004, 64'h0000_0002_0000_0000, 64'h4, 64'h0, ok);
        n_total++;
        if ({ok, host_resp_valid} !== 5'b1_0100)
            $display("FAIL sw_resp_valid: got %b want 1_0100", {ok, host_resp_valid});
        else n_pass++;
        n_total++;
        if ({host_resp_cmd, host_resp_dstaddr} !== {32'h0001_0004, 64'h0000_0002_0000_0000})
            $display("FAIL sw_resp_fields: got %h %h", host_resp_cmd, host_resp_dstaddr);
        else n_pass++;
        host_take(2);
        n_total++;
        if (host_resp_valid !== 4'b0000)
            $display("FAIL sw_resp_done: got %b want 0000", host_resp_valid);
        else n_pass++;
    endtask

    task automatic test_read_after_write();
        bit ok;
        logic [DW-1:0] mem_word;
        host_issue(0, 32'h0000_0003, 64'h8, 64'h10, 64'h1234, ok);
        n_total++;
        if ({ok, dev_req_dstaddr, dev_req_data} !== {1'b1, 64'h8, 64'h1234})
            $display("FAIL raw_write: got %b %h %h", ok, dev_req_dstaddr, dev_req_data);
        else n_pass++;
        mem_word = dev_req_data;
        dev_accept(ok);
        dev_respond(32'h0000_0004, 64'h10, 64'h8, 64'h0, ok);
        host_take(0);
        host_issue(0, 32'h0000_0001, 64'h8, 64'h10, 64'h0, ok);
        n_total++;
        if ({ok, dev_req_cmd[4:0]} !== {1'b1, 5'h01})
            $display("FAIL raw_read_req: got %b %h", ok, dev_req_cmd[4:0]);
        else n_pass++;
        dev_accept(ok);
        dev_respond(32'h0000_0002, 64'h10, 64'h8, mem_word, ok);
        n_total++;
        if ({host_resp_valid, host_resp_data, host_resp_cmd[4:0]} !==
            {4'b0001, 64'h1234, 5'h02})
            $display("FAIL raw_read_resp: got %b %h %h want 0001 1234 02", host_resp_valid,
                     host_resp_data, host_resp_cmd[4:0]);
        else n_pass++;
        host_take(0);
    endtask

    task automatic test_posted();
        bit ok;
        host_issue(1, 32'h0000_0005, 64'h20, 64'h200, 64'h55, ok);
        dev_accept(ok);
        n_total++;
        if ({ok, dev_req_valid, dev_resp_ready} !== 3'b100)
            $display("FAIL posted_idle: got %b want 100", {ok, dev_req_valid, dev_resp_ready});
        else n_pass++;
        // A stray device response outside WAIT must be held off.
        dev_resp_cmd   = 32'h4;
        dev_resp_data  = 64'hBAD;
        dev_resp_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if ({dev_resp_ready, host_resp_valid, dev_req_valid} !== 6'b0)
                $display("FAIL posted_no_resp%0d: got %b want 0", i,
                         {dev_resp_ready, host_resp_valid, dev_req_valid});
            else n_pass++;
            tick();
        end
        dev_resp_valid = 1'b0;
        host_req_valid = 4'b1000;
        #1;
        n_total++;
        if (host_req_ready !== 4'b1000)
            $display("FAIL posted_grant_ready: got %b want 1000", host_req_ready);
        else n_pass++;
        host_req_valid = 4'b0000;
    endtask

    task automatic test_backpressure();
        bit ok;
        host_issue(3, 32'h0000_0001, 64'h30, 64'h300, 64'h0, ok);
        dev_accept(ok);
        dev_respond(32'h0000_0002, 64'h300, 64'h30, 64'hCAFE_F00D_0000_0003, ok);
        for (int p = 0; p < 3; p++) host_req_cmd[p*CW +: CW] = 32'h0000_0005;
        host_req_valid  = 4'b0111;
        host_resp_ready = 4'b0111;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_total++;
            if ({host_resp_valid, host_resp_data, host_resp_cmd, host_req_ready} !==
                {4'b1000, 64'hCAFE_F00D_0000_0003, 32'h2, 4'b0000})
                $display("FAIL bp_hold%0d: got %b %h %h %b", i, host_resp_valid,
                         host_resp_data, host_resp_cmd, host_req_ready);
            else n_pass++;
            tick();
        end
        host_resp_ready = 4'b1000;
        tick();
        host_resp_ready = 4'b0000;
        #1;
        n_total++;
        if ({host_resp_valid, host_req_ready} !== 8'b0000_0001)
            $display("FAIL bp_release: got %b want 0000_0001", {host_resp_valid, host_req_ready});
        else n_pass++;
        host_req_valid = 4'b0000;
    endtask

    task automatic test_reset_mid();
        bit ok;
        tick();
        host_issue(0, 32'h0000_0001, 64'h40, 64'h400, 64'h0, ok);
        dev_accept(ok);
        n_total++;
        if ({ok, dev_resp_ready} !== 2'b11)
            $display("FAIL rst_mid_wait: got %b want 11", {ok, dev_resp_ready});
        else n_pass++;
        nreset = 1'b0;
        #1;
        n_total++;
        if ({dev_req_valid, dev_resp_ready, host_resp_valid, host_req_ready} !== 10'b0)
            $display("FAIL rst_mid_valids: got %b want 0",
                     {dev_req_valid, dev_resp_ready, host_resp_valid, host_req_ready});
        else n_pass++;
        n_total++;
        if ({host_resp_data, dev_req_dstaddr} !== 128'h0)
            $display("FAIL rst_mid_regs: got %h %h want 0", host_resp_data, dev_req_dstaddr);
        else n_pass++;
        tick();
        nreset = 1'b1;
        tick();
        host_issue(0, 32'h0000_0001, 64'h44, 64'h440, 64'h0, ok);
        n_total++;
        if ({ok, dev_req_valid, dev_req_dstaddr} !== {2'b11, 64'h44})
            $display("FAIL rst_mid_fresh_req: got %b %b %h", ok, dev_req_valid, dev_req_dstaddr);
        else n_pass++;
        dev_accept(ok);
        dev_respond(32'h0000_0002, 64'h440, 64'h44, 64'h77, ok);
        n_total++;
        if ({ok, host_resp_valid, host_resp_data} !== {1'b1, 4'b0001, 64'h77})
            $display("FAIL rst_mid_fresh_resp: got %b %b %h", ok, host_resp_valid,
                     host_resp_data);
        else n_pass++;
        host_take(0);
    endtask

    initial begin
        n_pass           = 0;
        n_total          = 0;
        nreset           = 1'b0;
        host_req_valid   = '0;
        host_req_cmd     = '0;
        host_req_dstaddr = '0;
        host_req_srcaddr = '0;
        host_req_data    = '0;
        host_resp_ready  = '0;
        dev_req_ready    = 1'b0;
        dev_resp_valid   = 1'b0;
        dev_resp_cmd     = '0;
        dev_resp_dstaddr = '0;
        dev_resp_srcaddr = '0;
        dev_resp_data    = '0;
        test_reset();
        test_fairness();
        test_single_write();
        test_read_after_write();
        test_posted();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule
